// File: rtl/rx_pkg.sv
// Shared types and constants for the UART frame sequencer.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OUT_PL   = 2'd1,
    IN_PL    = 2'd2,
    WAIT_ACK = 2'd3
  } rx_state_e;

  localparam logic [7:0] HDR_OUT_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR_IN_DEFAULT  = 8'h00;

  // True while a payload is being streamed to either channel.
  function automatic logic isPayloadState(input rx_state_e s);
    return (s == OUT_PL) || (s == IN_PL);
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: counts idle cycles and flags the terminal count.
module rx_gap_timer #(
  parameter int GAP_TIMEOUT = 20000
) (
  input  logic clock,
  input  logic nrst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int TW = $clog2(GAP_TIMEOUT);
  localparam logic [TW-1:0] TERMINAL = TW'(GAP_TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign tc_o = (count_q == TERMINAL);

  // Clear wins over counting; the count parks at terminal so it cannot wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame sequencer: decodes a header byte, steers a fixed-length payload to
// the OUT or IN channel, then holds that channel until it acknowledges.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter logic [7:0] HDR_OUT     = HDR_OUT_DEFAULT,
  parameter logic [7:0] HDR_IN      = HDR_IN_DEFAULT,
  parameter int         PAYLOAD_LEN = 4,
  parameter int         GAP_TIMEOUT = 20000
) (
  input  logic       clock,
  input  logic       nrst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       out_comp,
  input  logic       in_comp,
  output logic       vctr_out,
  output logic       vctr_in,
  output logic [7:0] pl_data,
  output logic       out_valid,
  output logic       in_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_LEN - 1);

  rx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        vctrOut_q, vctrOut_d;
  logic        vctrIn_q, vctrIn_d;
  logic [7:0]  plData_q, plData_d;
  logic        outValid_q, outValid_d;
  logic        inValid_q, inValid_d;
  logic        frameDone_q, frameDone_d;
  logic        frameErr_q, frameErr_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;
  logic        gapTc;
  logic        ack;

  // The timer only runs while streaming a payload; any byte restarts it.
  rx_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clock   (clock),
    .nrst    (nrst),
    .clear_i (byte_valid || !isPayloadState(state_q)),
    .enable_i(isPayloadState(state_q)),
    .tc_o    (gapTc)
  );

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vctrOut_d   = vctrOut_q;
    vctrIn_d    = vctrIn_q;
    plData_d    = plData_q;
    outValid_d  = 1'b0;
    inValid_d   = 1'b0;
    frameDone_d = 1'b0;
    frameErr_d  = 1'b0;
    overrun_d   = 1'b0;
    ack         = (vctrOut_q && out_comp) || (vctrIn_q && in_comp);

    case (state_q)
      IDLE: begin
        if (byte_valid) begin
          if (byte_data == HDR_OUT) begin
            state_d   = OUT_PL;
            vctrOut_d = 1'b1;
          end else if (byte_data == HDR_IN) begin
            state_d  = IN_PL;
            vctrIn_d = 1'b1;
          end
        end
      end
      OUT_PL, IN_PL: begin
        if (byte_valid) begin
          plData_d   = byte_data;
          outValid_d = (state_q == OUT_PL);
          inValid_d  = (state_q == IN_PL);
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = WAIT_ACK;
          end
        end else if (gapTc) begin
          frameErr_d = 1'b1;
          vctrOut_d  = 1'b0;
          vctrIn_d   = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          frameDone_d = 1'b1;
          vctrOut_d   = 1'b0;
          vctrIn_d    = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
        if (byte_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        vctrOut_d = 1'b0;
        vctrIn_d  = 1'b0;
        cnt_d     = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counter and registered outputs; reset aborts any frame silently.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vctrOut_q   <= 1'b0;
      vctrIn_q    <= 1'b0;
      plData_q    <= 8'h00;
      outValid_q  <= 1'b0;
      inValid_q   <= 1'b0;
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vctrOut_q   <= vctrOut_d;
      vctrIn_q    <= vctrIn_d;
      plData_q    <= plData_d;
      outValid_q  <= outValid_d;
      inValid_q   <= inValid_d;
      frameDone_q <= frameDone_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign vctr_out   = vctrOut_q;
  assign vctr_in    = vctrIn_q;
  assign pl_data    = plData_q;
  assign out_valid  = outValid_q;
  assign in_valid   = inValid_q;
  assign frame_done = frameDone_q;
  assign frame_err  = frameErr_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: a frame-level model predicts strobes
// and channel levels, a negedge monitor compares what the DUT presents.
module tb_rx_frame_ctrl;

  localparam logic [7:0] HOUT = 8'hA5;
  localparam logic [7:0] HIN  = 8'h00;
  localparam int PLEN = 4;
  localparam int GAP  = 50;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       vo;
    logic       vi;
    logic       bz;
    logic [7:0] pl;
  } lvl_t;

  logic       clock = 1'b0;
  logic       nrst = 1'b0;
  logic       byteValid = 1'b0;
  logic [7:0] byteData = 8'h00;
  logic       outComp = 1'b0;
  logic       inComp = 1'b0;
  logic       vctrOut, vctrIn, outValid, inValid, frameDone, frameErr, overrunS, busy;
  logic [7:0] plData;

  logic       b1Valid = 1'b0;
  logic [7:0] b1Data = 8'h00;
  logic       b1Out = 1'b0;
  logic       b1In = 1'b0;
  logic       b1VctrOut, b1VctrIn, b1OutValid, b1InValid, b1Done, b1Err, b1Overrun, b1Busy;
  logic [7:0] b1Pl;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  evQ[$];
  lvl_t lvlQ[$];
  string kindName[5] = '{"out_valid", "in_valid", "frame_done", "frame_err", "overrun"};

  int         mMode = 0;
  int         mChan = 0;
  int         mCount = 0;
  int         mSilent = 0;
  logic [7:0] mPl = 8'h00;

  rx_frame_ctrl #(
    .HDR_OUT(HOUT), .HDR_IN(HIN), .PAYLOAD_LEN(PLEN), .GAP_TIMEOUT(GAP)
  ) dut (
    .clock(clock), .nrst(nrst), .byte_valid(byteValid), .byte_data(byteData),
    .out_comp(outComp), .in_comp(inComp), .vctr_out(vctrOut), .vctr_in(vctrIn),
    .pl_data(plData), .out_valid(outValid), .in_valid(inValid), .frame_done(frameDone),
    .frame_err(frameErr), .overrun(overrunS), .busy(busy)
  );

  rx_frame_ctrl #(
    .HDR_OUT(HOUT), .HDR_IN(HIN), .PAYLOAD_LEN(1), .GAP_TIMEOUT(GAP)
  ) dut1 (
    .clock(clock), .nrst(nrst), .byte_valid(b1Valid), .byte_data(b1Data),
    .out_comp(b1Out), .in_comp(b1In), .vctr_out(b1VctrOut), .vctr_in(b1VctrIn),
    .pl_data(b1Pl), .out_valid(b1OutValid), .in_valid(b1InValid), .frame_done(b1Done),
    .frame_err(b1Err), .overrun(b1Overrun), .busy(b1Busy)
  );

  // Free-running clock and cycle stamp used to time-tag expectations.
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic pushEv(input int stamp, input int kind, input logic [7:0] data);
    ev_t e;
    e.cyc = stamp; e.kind = kind; e.data = data;
    evQ.push_back(e);
  endtask

  task automatic modelReset();
    mMode = 0; mChan = 0; mCount = 0; mSilent = 0; mPl = 8'h00;
  endtask

  // Frame-level reference: idle / payload(channel, count) / awaiting ack.
  task automatic modelStep(input logic v, input logic [7:0] b, input logic o, input logic i);
    int   stamp;
    lvl_t l;
    stamp = cyc + 1;
    case (mMode)
      0: if (v) begin
        if (b == HOUT) begin mMode = 1; mChan = 0; end
        else if (b == HIN) begin mMode = 1; mChan = 1; end
        mCount = 0; mSilent = 0;
      end
      1: if (v) begin
        mPl = b; pushEv(stamp, mChan, b); mCount++; mSilent = 0;
        if (mCount == PLEN) mMode = 2;
      end else begin
        mSilent++;
        if (mSilent == GAP) begin pushEv(stamp, 3, 8'h00); mMode = 0; end
      end
      default: begin
        if ((mChan == 0 && o) || (mChan == 1 && i)) begin pushEv(stamp, 2, 8'h00); mMode = 0; end
        if (v) pushEv(stamp, 4, 8'h00);
      end
    endcase
    l.cyc = stamp;
    l.vo = (mMode != 0) && (mChan == 0);
    l.vi = (mMode != 0) && (mChan == 1);
    l.bz = (mMode != 0);
    l.pl = mPl;
    lvlQ.push_back(l);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic o, input logic i);
    @(posedge clock);
    #1;
    byteValid = v; byteData = b; outComp = o; inComp = i;
    modelStep(v, b, o, i);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic sendBytes(input logic [7:0] bytes[$]);
    foreach (bytes[k]) applyStimulus(1'b1, bytes[k], 1'b0, 1'b0);
  endtask

  // Monitor: compare strobes and levels against the front of the queues.
  task automatic checkOutput();
    logic [4:0] sig;
    logic       exp;
    sig = {overrunS, frameErr, frameDone, inValid, outValid};
    while (evQ.size() > 0 && evQ[0].cyc < cyc) begin
      checkVal({"missing_", kindName[evQ[0].kind]}, 0, 1);
      void'(evQ.pop_front());
    end
    for (int k = 0; k < 5; k++) begin
      exp = (evQ.size() > 0) && (evQ[0].cyc == cyc) && (evQ[0].kind == k);
      if (sig[k] || exp) begin
        checkVal({"strobe_", kindName[k]}, int'(sig[k]), int'(exp));
        if (exp) begin
          if (k < 2) checkVal("pl_data_on_valid", int'(plData), int'(evQ[0].data));
          void'(evQ.pop_front());
        end
      end
    end
    while (lvlQ.size() > 0 && lvlQ[0].cyc < cyc) void'(lvlQ.pop_front());
    if (lvlQ.size() > 0 && lvlQ[0].cyc == cyc) begin
      checkVal("vctr_out", int'(vctrOut), int'(lvlQ[0].vo));
      checkVal("vctr_in", int'(vctrIn), int'(lvlQ[0].vi));
      checkVal("busy", int'(busy), int'(lvlQ[0].bz));
      checkVal("pl_data", int'(plData), int'(lvlQ[0].pl));
      void'(lvlQ.pop_front());
    end
  endtask

  always @(negedge clock) if (nrst) checkOutput();

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_vctr_out"}, int'(vctrOut), 0);
    checkVal({tag, "_vctr_in"}, int'(vctrIn), 0);
    checkVal({tag, "_pl_data"}, int'(plData), 0);
    checkVal({tag, "_out_valid"}, int'(outValid), 0);
    checkVal({tag, "_in_valid"}, int'(inValid), 0);
    checkVal({tag, "_frame_done"}, int'(frameDone), 0);
    checkVal({tag, "_frame_err"}, int'(frameErr), 0);
    checkVal({tag, "_overrun"}, int'(overrunS), 0);
    checkVal({tag, "_busy"}, int'(busy), 0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    #1;
    checkAllZero("reset");
    @(negedge clock);
    #2 nrst = 1'b1;

    // Single-byte payload variant on the second instance.
    @(posedge clock); #1 b1Valid = 1'b1; b1Data = HOUT;
    @(posedge clock); #1
    checkVal("len1_vctr_out_after_hdr", int'(b1VctrOut), 1);
    checkVal("len1_no_valid_on_hdr", int'(b1OutValid), 0);
    b1Data = 8'h9C;
    @(posedge clock); #1
    checkVal("len1_out_valid", int'(b1OutValid), 1);
    checkVal("len1_pl_data", int'(b1Pl), 8'h9C);
    b1Valid = 1'b0;
    @(posedge clock); #1
    checkVal("len1_valid_single", int'(b1OutValid), 0);
    checkVal("len1_wait_ack_busy", int'(b1Busy), 1);
    checkVal("len1_wait_ack_vctr", int'(b1VctrOut), 1);
    b1Out = 1'b1;
    @(posedge clock); #1
    checkVal("len1_frame_done", int'(b1Done), 1);
    checkVal("len1_vctr_cleared", int'(b1VctrOut), 0);
    checkVal("len1_idle", int'(b1Busy), 0);
    checkVal("len1_no_err", int'(b1Err | b1Overrun | b1InValid | b1VctrIn), 0);
    b1Out = 1'b0;

    // OUT frame with ack one cycle after the last byte.
    sendBytes('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44});
    idle(1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // IN frame carrying the OUT header as payload; wrong-channel ack ignored.
    sendBytes('{8'h00, 8'hA5, 8'h01, 8'h02, 8'h03});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Gap timeout, then a normal IN frame.
    sendBytes('{8'hA5, 8'h11});
    idle(GAP + 3);
    sendBytes('{8'h00, 8'h5A, 8'h6B, 8'h7C, 8'h8D});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Junk in idle, overrun while waiting, ack coincident with a byte.
    sendBytes('{8'h7F, 8'hFF, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    idle(1);
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a frame.
    sendBytes('{8'hA5, 8'h11});
    @(posedge clock);
    #3;
    nrst = 1'b0;
    byteValid = 1'b0;
    evQ.delete();
    lvlQ.delete();
    modelReset();
    #1;
    checkAllZero("midreset");
    @(posedge clock);
    @(posedge clock);
    #4 nrst = 1'b1;
    sendBytes('{8'hA5, 8'hC1, 8'hC2, 8'hC3, 8'hC4});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Byte arriving on the exact terminal-count cycle is accepted.
    sendBytes('{8'hA5});
    idle(GAP - 1);
    sendBytes('{8'h11});
    idle(GAP - 1);
    sendBytes('{8'h22, 8'h33, 8'h44});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Randomised traffic with occasional long silences.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r >= 97) begin
        idle($urandom_range(GAP - 3, GAP + 3));
      end else begin
        logic [7:0] b;
        case ($urandom_range(0, 3))
          0: b = HOUT;
          1: b = HIN;
          default: b = 8'($urandom_range(0, 255));
        endcase
        applyStimulus(r < 45, b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end
    idle(GAP + 5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    idle(3);

    if (evQ.size() != 0) checkVal("scoreboard_drained", evQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
